// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion: loads a cipher key, then derives one schedule word per clock
// (w4..w43) and presents all 44 words on the registered fullkeys bus.
module aes_key_schedule (
    input  logic            clk,
    input  logic            rst,
    input  logic            key_valid,
    input  logic [127:0]    key,
    output logic [1407:0]   fullkeys,
    output logic            busy,
    output logic            ready
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc_v;
        logic [7:0] sh_v;
        acc_v = 8'h00;
        sh_v  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc_v = acc_v ^ sh_v;
            end else begin
                acc_v = acc_v;
            end
            sh_v = xtime(sh_v);
        end
        return acc_v;
    endfunction

    // S-box computed as GF(2^8) inverse (a^254, with 0 mapping to 0) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv_v;
        logic [7:0] pw_v;
        inv_v = 8'h01;
        pw_v  = a;
        for (int i = 1; i < 8; i++) begin
            pw_v  = gf_mul(pw_v, pw_v);
            inv_v = gf_mul(inv_v, pw_v);
        end
        return inv_v ^ {inv_v[6:0], inv_v[7]} ^ {inv_v[5:0], inv_v[7:6]}
                     ^ {inv_v[4:0], inv_v[7:5]} ^ {inv_v[3:0], inv_v[7:4]} ^ 8'h63;
    endfunction

    state_t        state_r;
    state_t        state_nx_s;
    logic [5:0]    idx_r;
    logic [7:0]    rcon_r;
    logic [31:0]   w_r [0:43];
    logic          busy_r;
    logic          ready_r;
    logic          busy_nx_s;
    logic          ready_nx_s;
    logic          load_s;
    logic          step_s;
    logic [31:0]   prev_s;
    logic [31:0]   back_s;
    logic [31:0]   rot_s;
    logic [31:0]   sub_s;
    logic [31:0]   temp_s;
    logic [31:0]   new_word_s;

    for (genvar g = 0; g < 44; g++) begin : g_pack
        assign fullkeys[1407-32*g -: 32] = w_r[g];
    end

    assign busy  = busy_r;
    assign ready = ready_r;

    // State register and handshake flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= busy_nx_s;
            ready_r <= ready_nx_s;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_nx_s = state_r;
        busy_nx_s  = busy_r;
        ready_nx_s = ready_r;
        load_s     = 1'b0;
        step_s     = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (key_valid) begin
                    load_s     = 1'b1;
                    state_nx_s = ST_EXPAND;
                    busy_nx_s  = 1'b1;
                    ready_nx_s = 1'b0;
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_EXPAND: begin
                step_s = 1'b1;
                if (idx_r == 6'd43) begin
                    state_nx_s = ST_DONE;
                    busy_nx_s  = 1'b0;
                    ready_nx_s = 1'b1;
                end else begin
                    state_nx_s = ST_EXPAND;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                busy_nx_s  = 1'b0;
                ready_nx_s = 1'b0;
            end
        endcase
    end

    // Next schedule word from w[idx-1] and w[idx-4]
    always_comb begin
        prev_s = w_r[idx_r - 6'd1];
        back_s = w_r[idx_r - 6'd4];
        rot_s  = {prev_s[23:0], prev_s[31:24]};
        sub_s  = {sbox(rot_s[31:24]), sbox(rot_s[23:16]), sbox(rot_s[15:8]), sbox(rot_s[7:0])};
        if (idx_r[1:0] == 2'b00) begin
            temp_s = sub_s ^ {rcon_r, 24'h000000};
        end else begin
            temp_s = prev_s;
        end
        new_word_s = back_s ^ temp_s;
    end

    // Word storage, index and round constant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 44; i++) begin
                w_r[i] <= 32'h00000000;
            end
            idx_r  <= 6'd0;
            rcon_r <= 8'h01;
        end else if (load_s) begin
            w_r[0] <= key[127:96];
            w_r[1] <= key[95:64];
            w_r[2] <= key[63:32];
            w_r[3] <= key[31:0];
            idx_r  <= 6'd4;
            rcon_r <= 8'h01;
        end else if (step_s) begin
            w_r[idx_r] <= new_word_s;
            idx_r      <= idx_r + 6'd1;
            if (idx_r[1:0] == 2'b00) begin
                rcon_r <= xtime(rcon_r);
            end else begin
                rcon_r <= rcon_r;
            end
        end else begin
            idx_r  <= idx_r;
            rcon_r <= rcon_r;
        end
    end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed testbench for aes_key_schedule using FIPS-197 and all-zero key vectors.
module tb_aes_key_schedule;

    logic            clk;
    logic            rst;
    logic            key_valid;
    logic [127:0]    key;
    logic [1407:0]   fullkeys;
    logic            busy;
    logic            ready;

    int checks;
    int failures;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_KEY = 128'h0;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    aes_key_schedule dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key       (key),
        .fullkeys  (fullkeys),
        .busy      (busy),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents k for one edge; returns #1 after the accepting edge
    task automatic accept_key(input logic [127:0] k);
        key       = k;
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; key_valid = 1'b0; key = 128'h0;
        #2 rst = 1'b0;
        #1;
        checks++; if (fullkeys !== 1408'h0) begin failures++; $display("FAIL reset_fullkeys got %h", fullkeys[1407:1280]); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got %b want 0", ready); end
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || ready !== 1'b0) begin failures++; $display("FAIL idle_hold busy=%b ready=%b want 0/0", busy, ready); end
    endtask

    task automatic test_fips;
        int cnt;
        accept_key(FIPS_KEY);
        checks++; if (busy !== 1'b1 || ready !== 1'b0) begin failures++; $display("FAIL fips_accept busy=%b ready=%b want 1/0", busy, ready); end
        checks++; if (fullkeys[1407:1280] !== FIPS_KEY) begin failures++; $display("FAIL fips_round0 got %h want %h", fullkeys[1407:1280], FIPS_KEY); end
        @(posedge clk); #1;
        cnt = 1;
        checks++; if (fullkeys[1279:1248] !== 32'ha0fafe17) begin failures++; $display("FAIL fips_w4 got %h want a0fafe17", fullkeys[1279:1248]); end
        while (ready !== 1'b1 && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        checks++; if (cnt !== 40) begin failures++; $display("FAIL fips_latency got %0d want 40", cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fips_busy_done got %b want 0", busy); end
        checks++; if (fullkeys[1279:1152] !== FIPS_R1) begin failures++; $display("FAIL fips_round1 got %h want %h", fullkeys[1279:1152], FIPS_R1); end
        checks++; if (fullkeys[127:0] !== FIPS_R10) begin failures++; $display("FAIL fips_round10 got %h want %h", fullkeys[127:0], FIPS_R10); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ready !== 1'b1 || fullkeys[127:0] !== FIPS_R10) begin failures++; $display("FAIL fips_done_hold ready=%b r10=%h", ready, fullkeys[127:0]); end
    endtask

    task automatic test_done_reload_zero;
        int bad;
        accept_key(ZERO_KEY);
        checks++; if (ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL reload_edge ready=%b busy=%b want 0/1", ready, busy); end
        checks++; if (fullkeys[1407:1280] !== ZERO_KEY) begin failures++; $display("FAIL zero_round0 got %h want 0", fullkeys[1407:1280]); end
        bad = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (ready !== (n == 40) || busy !== (n != 40)) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL zero_sequencing got %0d bad cycles want 0", bad); end
        checks++; if (fullkeys[1279:1152] !== ZERO_R1) begin failures++; $display("FAIL zero_round1 got %h want %h", fullkeys[1279:1152], ZERO_R1); end
        checks++; if (fullkeys[127:0] !== ZERO_R10) begin failures++; $display("FAIL zero_round10 got %h want %h", fullkeys[127:0], ZERO_R10); end
    endtask

    task automatic test_ignore_during_expand;
        int cnt;
        accept_key(FIPS_KEY);
        repeat (9) @(posedge clk);
        #1;
        key = ZERO_KEY; key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0; key = FIPS_KEY;
        cnt = 10;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ignore_busy got %b want 1", busy); end
        while (ready !== 1'b1 && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        checks++; if (cnt !== 40) begin failures++; $display("FAIL ignore_latency got %0d want 40", cnt); end
        checks++; if (fullkeys[1407:1280] !== FIPS_KEY) begin failures++; $display("FAIL ignore_round0 got %h want %h", fullkeys[1407:1280], FIPS_KEY); end
        checks++; if (fullkeys[1279:1152] !== FIPS_R1) begin failures++; $display("FAIL ignore_round1 got %h want %h", fullkeys[1279:1152], FIPS_R1); end
        checks++; if (fullkeys[127:0] !== FIPS_R10) begin failures++; $display("FAIL ignore_round10 got %h want %h", fullkeys[127:0], FIPS_R10); end
    endtask

    task automatic test_reset_mid_expand;
        accept_key(FIPS_KEY);
        repeat (19) @(posedge clk);
        #4 rst = 1'b0;
        #1;
        checks++; if (fullkeys !== 1408'h0) begin failures++; $display("FAIL midreset_fullkeys got %h want 0", fullkeys[1407:1280]); end
        checks++; if (busy !== 1'b0 || ready !== 1'b0) begin failures++; $display("FAIL midreset_flags busy=%b ready=%b want 0/0", busy, ready); end
        #2 rst = 1'b1;
        repeat (45) @(posedge clk);
        #1;
        checks++; if (fullkeys !== 1408'h0 || busy !== 1'b0 || ready !== 1'b0) begin
            failures++; $display("FAIL postreset_idle busy=%b ready=%b r0=%h want 0", busy, ready, fullkeys[1407:1280]);
        end
    endtask

    task automatic test_back_to_back;
        int bad_flags;
        int bad_keys;
        int pulses;
        rst = 1'b0; key = FIPS_KEY; key_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1 || fullkeys[1407:1280] !== FIPS_KEY) begin
            failures++; $display("FAIL release_accept busy=%b r0=%h want 1/%h", busy, fullkeys[1407:1280], FIPS_KEY);
        end
        bad_flags = 0; bad_keys = 0; pulses = 0;
        for (int n = 1; n <= 123; n++) begin
            @(posedge clk); #1;
            if (ready !== ((n % 41) == 40) || busy !== ((n % 41) != 40)) bad_flags++;
            if (ready === 1'b1) begin
                pulses++;
                if (fullkeys[127:0] !== FIPS_R10) bad_keys++;
            end
        end
        key_valid = 1'b0;
        checks++; if (bad_flags !== 0) begin failures++; $display("FAIL b2b_flags got %0d bad cycles want 0", bad_flags); end
        checks++; if (pulses !== 3) begin failures++; $display("FAIL b2b_pulses got %0d want 3", pulses); end
        checks++; if (bad_keys !== 0) begin failures++; $display("FAIL b2b_schedule got %0d bad want 0", bad_keys); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset;
        test_fips;
        test_done_reload_zero;
        test_ignore_during_expand;
        test_reset_mid_expand;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Iterative AES-128 key expansion stage that sits directly upstream of the AES encryption core. It accepts a 128-bit cipher key and generates the 44 expanded words (11 round keys) one word per clock, presenting them on the 1408-bit `fullkeys` bus the core consumes. It replaces the purely combinational expander with a registered, one-S-box-word-per-cycle datapath and a valid/ready handshake.

## Interface
- No parameters. Key size is fixed at 128 bits, Nk=4, Nr=10.
- `clk`  input  1  system clock; all state updates on its rising edge.
- `rst`  input  1  asynchronous, active-low reset; low forces the reset state immediately.
- `key_valid`  input  1  request to expand `key`; sampled on `clk` in IDLE or DONE only.
- `key`  input  128  cipher key, word 0 in `[127:96]`; sampled only on the accepting edge.
- `fullkeys`  output  1408  expanded schedule, registered. Word w[i] occupies `[1407-32*i -: 32]`. Round key r occupies `[128*(11-r)-1 -: 128]`, so round 0 is `[1407:1280]`.
- `busy`  output  1  high while expansion is in progress.
- `ready`  output  1  high when `fullkeys` holds a complete schedule for the last accepted key.

## Operation
- States: IDLE, EXPAND, DONE. Registers: 6-bit word index `idx`, 8-bit `rcon`.
- IDLE:
  - With `key_valid`=1: write `key` to w0..w3, set `idx`=4 and `rcon`=8'h01, set `busy`=1, go to EXPAND.
  - Otherwise hold.
- EXPAND, one word per cycle:
  - temp = w[idx-1].
  - If `idx[1:0]`==0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, then `rcon` <= xtime(rcon). RotWord is a left rotate by one byte. SubWord uses four FIPS-197 S-box lookups. xtime is a shift left by 1, XORed with 8'h1b if the old MSB was set.
  - w[idx] <= w[idx-4] ^ temp, then `idx` <= `idx`+1.
  - When the word just written is w43: `busy`<=0, `ready`<=1, go to DONE.
- DONE:
  - Hold `fullkeys` and keep `ready`=1.
  - With `key_valid`=1: behave exactly as the IDLE accept (`ready`<=0, `busy`<=1, reload w0..w3).
- `key_valid` during EXPAND is ignored. There is no queuing, and the in-flight expansion is unaffected.
- All XOR arithmetic is 32-bit with no carries. `rcon` takes the sequence 01,02,04,08,10,20,40,80,1b,36 for words 4,8,…,40.
- Words w4..w43 that have not yet been written hold stale contents. The consumer must treat `fullkeys` as valid only while `ready`=1.

## Timing
- Reset values: `fullkeys`=0, `busy`=0, `ready`=0, state IDLE, `idx`=0, `rcon`=8'h01.
- Accepting edge E0:
  - w0..w3 are visible after E0, and `busy`=1.
  - Edges E1..E40 write w4..w43.
  - At E40: `ready`=1, `busy`=0.
  - Latency from the sampling edge to `ready` is 40 cycles.
- `ready` falls on the edge that accepts a new key. `busy` and `ready` are never both 1.
- Back-to-back operation: `key_valid` held high continuously restarts on the cycle after each DONE entry. The throughput is 41 cycles per key.
- Reset asserted mid-EXPAND: all outputs return to their reset values asynchronously. After release, the block waits in IDLE for a new `key_valid`. It does not resume.
- Reset releasing while `key_valid`=1: the key is accepted on the first rising edge after release.

## Test plan
- FIPS-197 A.1 key `2b7e151628aed2a6abf7158809cf4f3c`:
  - w4 = `a0fafe17` one edge after E1.
  - Round 1 key = `a0fafe1788542cb123a339392a6c7605`.
  - Round 10 key = `d014f9a8c9ee2589e13f0cc8b6630ca6`.
  - `ready` rises exactly 40 edges after acceptance.
- All-zero key:
  - Round 1 = `62636363626363636263636362636363`.
  - Round 10 = `b4ef5bcb3e92e21123e951cf6f8f188e`.
  - `busy`/`ready` sequencing is checked.
- Accept FIPS key, then pulse `key_valid` with the zero key at E10:
  - The pulse is ignored.
  - The final schedule matches the FIPS vector, and `ready` timing is unchanged.
- In DONE with the FIPS schedule, apply the zero key:
  - `ready` drops on that edge.
  - 40 edges later `ready`=1 with the zero-key schedule.
- Drive `rst`=0 asynchronously between edges at E20:
  - `fullkeys`=0, `busy`=0, `ready`=0 immediately.
  - After release with no `key_valid`, outputs remain at reset values.
- Hold `key_valid`=1 permanently:
  - `ready` pulses high for exactly one cycle every 41 cycles.
  - `busy` is low only during that cycle.
